sync_down_timer: RTL

SYNC_DOWN_TIMER -- requirements
Module: sync_down_timer

---
 rtl/sync_down_timer.sv | 114 +++++++++++
 1 files changed

// File: rtl/sync_down_timer.sv
// Loadable down-counter with IDLE/RUN/DONE control and a one-cycle terminal-count pulse.
// Define SYNC_DOWN_TIMER_AUTO_RELOAD_EN to reload from the reload register at terminal count instead of stopping.
module sync_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State and registered outputs; clear wins over everything.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next state, count and reload value.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = (load_value != '0) ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!en) begin
            count_d = count_q;
          end else if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else if (count_q == WIDTH'(1)) begin
            tc_d = 1'b1;
`ifdef SYNC_DOWN_TIMER_AUTO_RELOAD_EN
            count_d = reload_q;
            state_d = ST_RUN;
`else
            count_d = '0;
            state_d = ST_DONE;
`endif
          end else begin
            // A zero count in RUN is unreachable; restart from the reload value or fall back to IDLE.
            count_d = reload_q;
            state_d = (reload_q != '0) ? ST_RUN : ST_IDLE;
          end
        end
        ST_IDLE: count_d = count_q;
        ST_DONE: count_d = count_q;
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // Status flags decoded from the upcoming state so they register alongside it.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_RUN:  busy_d = 1'b1;
      ST_DONE: done_d = 1'b1;
      ST_IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule
